// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the ARM datapath.
// The FSM side is the master: it samples instruction class/handshake and drives the controls.
interface multicycle_main_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic       is_mult;
  logic       is_bx;
  logic       mem_ready;

  logic       ir_write;
  logic       next_pc;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       reg_w;
  logic       mem_w;
  logic       alu_op;
  logic       branch;
  logic       mult;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, is_mult, is_bx, mem_ready,
    output ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           reg_w, mem_w, alu_op, branch, mult, instr_done, illegal, state
  );

  modport slave (
    output op, funct, is_mult, is_bx, mem_ready,
    input  ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           reg_w, mem_w, alu_op, branch, mult, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle ARM core: sequences fetch/decode/execute/
// memory/writeback and drives datapath selects, write enables and ALU qualifiers.
module multicycle_main_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multicycle_main_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_EXECM  = 4'd10
  } state_e;

  state_e state_q, state_d;

  logic       mem_rdy;
  logic       ir_write_c, next_pc_c, reg_w_c, mem_w_c;
  logic       adr_src_c, alu_op_c, branch_c, mult_c, instr_done_c, illegal_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;

  assign mem_rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    ir_write_c   = 1'b0;
    next_pc_c    = 1'b0;
    adr_src_c    = 1'b0;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    result_src_c = 2'b00;
    reg_w_c      = 1'b0;
    mem_w_c      = 1'b0;
    alu_op_c     = 1'b0;
    branch_c     = 1'b0;
    mult_c       = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        alu_src_a_c  = 2'b01;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        if (mem_rdy) begin
          ir_write_c = 1'b1;
          next_pc_c  = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_c  = 2'b01;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        unique case (bus.op)
          2'b00: begin
            if (bus.is_mult)       state_d = S_EXECM;
            else if (bus.is_bx)    state_d = S_BRANCH;
            else if (bus.funct[5]) state_d = S_EXECI;
            else                   state_d = S_EXECR;
          end
          2'b01: state_d = S_MEMADR;
          2'b10: state_d = S_BRANCH;
          default: begin
            illegal_c    = 1'b1;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_b_c = 2'b01;
        state_d     = bus.funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src_c = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_w_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        adr_src_c = 1'b1;
        mem_w_c   = 1'b1;
        if (mem_rdy) begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_op_c = 1'b1;
        state_d  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b_c = 2'b01;
        alu_op_c    = 1'b1;
        state_d     = S_ALUWB;
      end
      S_EXECM: begin
        mult_c  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c  = 2'b10;
        alu_src_b_c  = bus.is_bx ? 2'b00 : 2'b01;
        branch_c     = 1'b1;
        result_src_c = 2'b10;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset holds state at FETCH, whose outputs would otherwise fetch; keep every write enable low.
  assign bus.ir_write   = ir_write_c & reset_n;
  assign bus.next_pc    = next_pc_c  & reset_n;
  assign bus.reg_w      = reg_w_c    & reset_n;
  assign bus.mem_w      = mem_w_c    & reset_n;
  assign bus.adr_src    = adr_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.branch     = branch_c;
  assign bus.mult       = mult_c;
  assign bus.instr_done = instr_done_c;
  assign bus.illegal    = illegal_c;
  assign bus.state      = state_q;

endmodule
